// File: rtl/fxp_alu_pkg.sv
// ============================================================================
// Module      : fxp_alu_pkg
// Description : Shared op codes, FSM state type and saturation helpers for
//               the fixed-point ALU.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fxp_alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    DIV  = 1'b1
  } state_t;

  // Helpers work on a wide fixed container so they serve every legal N.
  typedef struct packed {
    logic         ovf;
    logic [127:0] val;
  } sat_t;

  function automatic logic [127:0] fxp_mag(input logic [127:0] x);
    return x[127] ? (~x + 128'd1) : x;
  endfunction

  function automatic sat_t fxp_sat(input logic neg, input logic [127:0] mag, input int n);
    sat_t         s;
    logic [127:0] lim;
    logic [127:0] m;
    lim   = (128'd1 << (n - 1)) - 128'd1;
    s.ovf = (mag > lim);
    m     = s.ovf ? lim : mag;
    s.val = neg ? (~m + 128'd1) : m;
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fxp_alu_if.sv
// ============================================================================
// Module      : fxp_alu_if
// Description : Valid/ready operand and result bundle of the fixed-point ALU.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fxp_alu_if #(
  parameter int N = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [1:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] result;
  logic         ovf;
  logic         dz;
  logic         busy;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, ovf, dz, busy
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, ovf, dz, busy
  );
endinterface

`default_nettype wire

// File: rtl/fxp_div_seq.sv
// ============================================================================
// Module      : fxp_div_seq
// Description : Iterative restoring unsigned divider, one quotient bit per
//               cycle; the dividend carries one bit above the ITERS produced.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fxp_div_seq #(
  parameter int VW    = 32,
  parameter int ITERS = 43
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [ITERS:0]   dividend,
  input  logic [VW-1:0]    divisor,
  output logic             done,
  output logic [ITERS-1:0] quotient,
  output logic             q_ovf
);

  localparam int c_CW = $clog2(ITERS + 1);

  logic [VW-1:0]    r_div;
  logic [VW-1:0]    r_rem;
  logic [ITERS-1:0] r_dvd;
  logic [ITERS-2:0] r_quo;
  logic [c_CW-1:0]  r_cnt;
  logic             r_active;
  logic             r_ovf;

  logic [VW:0]      w_trial;
  logic [VW+1:0]    w_diff;
  logic             w_bit;
  logic [VW-1:0]    w_rem_nxt;
  logic             w_top_ovf;
  logic [VW-1:0]    w_rem0;
  logic             w_unused;

  assign w_trial   = {r_rem, r_dvd[ITERS-1]};
  assign w_diff    = {1'b0, w_trial} - {2'b00, r_div};
  assign w_bit     = ~w_diff[VW+1];
  assign w_rem_nxt = w_bit ? w_diff[VW-1:0] : w_trial[VW-1:0];

  // The dividend bit above the produced quotient only overflows it for divisor 1.
  assign w_top_ovf = dividend[ITERS] && (divisor == {{(VW-1){1'b0}}, 1'b1});
  assign w_rem0    = w_top_ovf ? '0 : {{(VW-1){1'b0}}, dividend[ITERS]};

  assign done     = r_active && (r_cnt == c_CW'(ITERS - 1));
  assign quotient = {r_quo, w_bit};
  assign q_ovf    = r_ovf;
  assign w_unused = ^{w_trial[VW], w_diff[VW]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active <= 1'b0;
      r_cnt    <= '0;
      r_div    <= '0;
      r_rem    <= '0;
      r_dvd    <= '0;
      r_quo    <= '0;
      r_ovf    <= 1'b0;
    end else if (start) begin
      r_active <= 1'b1;
      r_cnt    <= '0;
      r_div    <= divisor;
      r_rem    <= w_rem0;
      r_dvd    <= dividend[ITERS-1:0];
      r_quo    <= '0;
      r_ovf    <= w_top_ovf;
    end else if (r_active) begin
      r_rem <= w_rem_nxt;
      r_dvd <= {r_dvd[ITERS-2:0], 1'b0};
      r_quo <= {r_quo[ITERS-3:0], w_bit};
      r_cnt <= r_cnt + c_CW'(1);
      if (done) begin
        r_active <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fxp_alu_seq.sv
// ============================================================================
// Module      : fxp_alu_seq
// Description : Saturating signed Qm.Q ALU (add/sub/mul single cycle, divide
//               iterative) with valid/ready streaming handshake.
//               FXP_ALU_ROUND_EN : round half away from zero on mul/div.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fxp_alu_seq
  import fxp_alu_pkg::*;
#(
  parameter int N = 32,
  parameter int Q = 12
) (
  input  logic      clk,
  input  logic      rst_n,
  fxp_alu_if.slave  bus
);

  localparam int DIV_ITERS = N - 1 + Q;
`ifdef FXP_ALU_ROUND_EN
  localparam int c_RND = 1;
`else
  localparam int c_RND = 0;
`endif
  localparam int c_STEPS = DIV_ITERS + c_RND;

  state_t         r_state;
  logic           r_out_valid;
  logic [N-1:0]   r_result;
  logic           r_ovf;
  logic           r_dz;
  logic           r_busy;
  logic           r_neg;

  logic [127:0]   w_a128;
  logic [127:0]   w_b128;
  logic [N-1:0]   w_amag;
  logic [N-1:0]   w_bmag;
  logic           w_b_zero;
  logic signed [N:0] w_sum;
  logic [2*N-1:0] w_prod;
  logic [2*N-1:0] w_pmag;
  sat_t           w_sat_as;
  sat_t           w_sat_mul;
  sat_t           w_sat_dz;
  sat_t           w_sat_div;
  sat_t           w_fast;
  logic           w_fast_dz;
  logic [c_STEPS:0]   w_dvd;
  logic [c_STEPS-1:0] w_quo;
  logic [c_STEPS-1:0] w_qmag;
  logic [127:0]   w_qmag128;
  logic           w_q_ovf;
  logic           w_div_done;
  logic           w_in_ready;
  logic           w_accept;
  logic           w_div_start;
  logic           w_fast_load;
  logic           w_unused;

  // Magnitudes are N bits wide so the -2^(N-1) input code maps to 2^(N-1).
  assign w_a128   = fxp_mag(128'($signed(bus.a)));
  assign w_b128   = fxp_mag(128'($signed(bus.b)));
  assign w_amag   = w_a128[N-1:0];
  assign w_bmag   = w_b128[N-1:0];
  assign w_b_zero = (bus.b == '0);

  always_comb begin
    if (bus.op == OP_SUB) begin
      w_sum = $signed({bus.a[N-1], bus.a}) - $signed({bus.b[N-1], bus.b});
    end else begin
      w_sum = $signed({bus.a[N-1], bus.a}) + $signed({bus.b[N-1], bus.b});
    end
  end

  assign w_sat_as = fxp_sat(w_sum[N], fxp_mag(128'(w_sum)), N);

  assign w_prod = (2*N)'(w_amag) * (2*N)'(w_bmag);
`ifdef FXP_ALU_ROUND_EN
  assign w_pmag = (w_prod >> Q) + (2*N)'(w_prod[Q-1]);
`else
  assign w_pmag = w_prod >> Q;
`endif
  assign w_sat_mul = fxp_sat(bus.a[N-1] ^ bus.b[N-1], 128'(w_pmag), N);

  // Divide by zero: any oversized magnitude forces the signed bound.
  assign w_sat_dz = fxp_sat(bus.a[N-1], (bus.a == '0) ? 128'd0 : (128'd1 << N), N);

  always_comb begin
    w_fast    = w_sat_as;
    w_fast_dz = 1'b0;
    case (bus.op)
      OP_MUL:  w_fast = w_sat_mul;
      OP_DIV: begin
        w_fast    = w_sat_dz;
        w_fast_dz = 1'b1;
      end
      default: w_fast = w_sat_as;
    endcase
  end

  assign w_dvd = {w_amag, {(Q + c_RND){1'b0}}};

  fxp_div_seq #(
    .VW    (N),
    .ITERS (c_STEPS)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (w_div_start),
    .dividend (w_dvd),
    .divisor  (w_bmag),
    .done     (w_div_done),
    .quotient (w_quo),
    .q_ovf    (w_q_ovf)
  );

`ifdef FXP_ALU_ROUND_EN
  // Last quotient bit is the guard bit.
  assign w_qmag = (w_quo >> 1) + c_STEPS'(w_quo[0]);
`else
  assign w_qmag = w_quo;
`endif
  assign w_qmag128 = w_q_ovf ? (128'd1 << N) : 128'(w_qmag);
  assign w_sat_div = fxp_sat(r_neg, w_qmag128, N);

  assign w_in_ready  = rst_n && (r_state == IDLE) && (!r_out_valid || bus.out_ready);
  assign w_accept    = bus.in_valid && w_in_ready;
  assign w_div_start = w_accept && (bus.op == OP_DIV) && !w_b_zero;
  assign w_fast_load = w_accept && !w_div_start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_ovf       <= 1'b0;
      r_dz        <= 1'b0;
      r_busy      <= 1'b0;
      r_neg       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_div_start) begin
            r_state <= DIV;
            r_busy  <= 1'b1;
            r_neg   <= bus.a[N-1] ^ bus.b[N-1];
          end
        end
        DIV: begin
          if (w_div_done) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
      endcase

      if (w_fast_load) begin
        r_out_valid <= 1'b1;
        r_result    <= w_fast.val[N-1:0];
        r_ovf       <= w_fast.ovf;
        r_dz        <= w_fast_dz;
      end else if ((r_state == DIV) && w_div_done) begin
        r_out_valid <= 1'b1;
        r_result    <= w_sat_div.val[N-1:0];
        r_ovf       <= w_sat_div.ovf;
        r_dz        <= 1'b0;
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
  assign bus.ovf       = r_ovf;
  assign bus.dz        = r_dz;
  assign bus.busy      = r_busy;

  assign w_unused = ^{w_a128[127:N], w_b128[127:N], w_fast.val[127:N], w_sat_div.val[127:N]};

endmodule

`default_nettype wire

// File: tb/tb_fxp_alu_seq.sv
// ============================================================================
// Module      : tb_fxp_alu_seq
// Description : Scoreboard bench for fxp_alu_seq (N=32, Q=12) with an
//               integer-arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fxp_alu_seq;
  import fxp_alu_pkg::*;

  localparam int N = 32;
  localparam int Q = 12;
  localparam int DIV_ITERS = N - 1 + Q;
`ifdef FXP_ALU_ROUND_EN
  localparam bit ROUND   = 1'b1;
  localparam int DIV_LAT = DIV_ITERS + 2;
`else
  localparam bit ROUND   = 1'b0;
  localparam int DIV_LAT = DIV_ITERS + 1;
`endif

  typedef struct {
    logic [N-1:0] res;
    logic         ovf;
    logic         dz;
    int           cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  bit   fresh = 1'b1;
  bit   bp_rand = 1'b0;
  bit   bp_fixed = 1'b1;

  fxp_alu_if #(.N(N)) bus();

  fxp_alu_seq #(.N(N), .Q(Q)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain signed arithmetic on the real values, then clamp.
  function automatic exp_t model(input logic [1:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    exp_t   e;
    longint sa, sb, ma, mb, v, mag, lim, one_q;
    bit     neg;
    sa    = longint'($signed(a));
    sb    = longint'($signed(b));
    ma    = (sa < 0) ? -sa : sa;
    mb    = (sb < 0) ? -sb : sb;
    lim   = (longint'(1) <<< (N - 1)) - 1;
    one_q = longint'(1) <<< Q;
    e.dz  = 1'b0;
    neg   = 1'b0;
    mag   = 0;
    case (op)
      OP_ADD, OP_SUB: begin
        v   = (op == OP_ADD) ? sa + sb : sa - sb;
        neg = (v < 0);
        mag = neg ? -v : v;
      end
      OP_MUL: begin
        neg = (sa < 0) != (sb < 0);
        mag = ROUND ? (ma * mb + one_q / 2) / one_q : (ma * mb) / one_q;
      end
      default: begin
        if (sb == 0) begin
          e.dz = 1'b1;
          neg  = (sa < 0);
          mag  = (sa == 0) ? 0 : lim + 1;
        end else begin
          neg = (sa < 0) != (sb < 0);
          mag = ROUND ? (ma * one_q * 2 + mb) / (2 * mb) : (ma * one_q) / mb;
        end
      end
    endcase
    e.ovf = (mag > lim);
    if (e.ovf) mag = lim;
    if (neg) mag = -mag;
    e.res = N'(mag);
    e.cyc = 0;
    return e;
  endfunction

  // Consumer side: out_ready either fixed or randomly toggled.
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = bp_rand ? ($urandom_range(0, 9) < 7) : bp_fixed;
    end
  end

  // Monitor: every visible output is checked against the scoreboard head.
  initial forever begin
    @(negedge clk);
    if (rst_n && bus.out_valid) begin
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_output: got result 0x%0h, expected no output", bus.result);
      end else begin
        if (fresh) begin
          check("latency", 64'(cyc), 64'(sb_q[0].cyc));
          fresh = 1'b0;
        end
        check("result", 64'(bus.result), 64'(sb_q[0].res));
        check("ovf", 64'(bus.ovf), 64'(sb_q[0].ovf));
        check("dz", 64'(bus.dz), 64'(sb_q[0].dz));
        if (bus.out_ready) begin
          void'(sb_q.pop_front());
          fresh = 1'b1;
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the beat is accepted.
  task automatic send(input logic [1:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    exp_t e;
    int   waited = 0;
    bus.op = op;
    bus.a  = a;
    bus.b  = b;
    bus.in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.in_ready || waited > 200) break;
      waited++;
    end
    if (!bus.in_ready) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: got in_ready=0 for %0d cycles, expected acceptance", waited);
    end else begin
      e = model(op, a, b);
      e.cyc = cyc + (((op == OP_DIV) && (b != '0)) ? DIV_LAT : 1);
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sb_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got %0d pending results, expected 0", sb_q.size());
    end
  endtask

  function automatic logic [N-1:0] rand_opnd();
    logic [N-1:0] specials [5];
    logic [N-1:0] v;
    int           sel;
    specials[0] = 32'h0000_0000;
    specials[1] = 32'h8000_0000;
    specials[2] = 32'h7FFF_FFFF;
    specials[3] = 32'h0000_1000;
    specials[4] = 32'hFFFF_F000;
    sel = $urandom_range(0, 9);
    if (sel == 0) begin
      v = specials[$urandom_range(0, 4)];
    end else if (sel < 5) begin
      v = N'($urandom_range(0, 16 * 4096));
      if ($urandom_range(0, 1) == 1) v = -v;
    end else begin
      v = $urandom;
    end
    return v;
  endfunction

  initial begin
    #900000;
    $display("FAIL watchdog: got no completion, expected $finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r;
    logic [1:0] op;
    bus.in_valid = 1'b0;
    bus.a  = '0;
    bus.b  = '0;
    bus.op = OP_ADD;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_result", 64'(bus.result), 64'd0);
    check("rst_ovf", 64'(bus.ovf), 64'd0);
    check("rst_dz", 64'(bus.dz), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed single-cycle ops, issued back to back.
    send(OP_ADD, 32'h0000_1800, 32'h0000_2000);
    send(OP_SUB, 32'h0000_1800, 32'h0000_2000);
    send(OP_MUL, 32'h0000_1800, 32'hFFFF_E000);
    send(OP_MUL, 32'h7FFF_FFFF, 32'h0000_2000);
    send(OP_ADD, 32'h8000_0000, 32'h0000_0000);
    send(OP_MUL, 32'h8000_0000, 32'h0000_1000);

    // Divide: busy high and in_ready low for the whole iteration.
    send(OP_DIV, 32'h0000_3000, 32'h0000_2000);
    for (int k = 1; k < DIV_LAT; k++) begin
      @(negedge clk);
      check("div_busy", 64'(bus.busy), 64'd1);
      check("div_in_ready", 64'(bus.in_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    send(OP_DIV, 32'hFFFF_F000, 32'h0000_0000);
    send(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001);
    send(OP_DIV, 32'h0000_0000, 32'h0000_0000);
    send(OP_DIV, 32'h8000_0000, 32'h0000_0001);
    wait_drain();

    // Backpressure: result held, second beat stalled until out_ready rises.
    bp_fixed = 1'b0;
    @(posedge clk);
    #1;
    send(OP_ADD, 32'h0000_1000, 32'h0000_1000);
    bus.op = OP_MUL;
    bus.a  = 32'h0000_3000;
    bus.b  = 32'h0000_3000;
    bus.in_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("bp_in_ready", 64'(bus.in_ready), 64'd0);
    end
    bp_fixed = 1'b1;
    @(posedge clk);
    #2;
    check("bp_release_in_ready", 64'(bus.in_ready), 64'd1);
    send(OP_MUL, 32'h0000_3000, 32'h0000_3000);
    wait_drain();

    // Reset in the middle of a divide.
    send(OP_DIV, 32'h0000_5000, 32'h0000_3000);
    repeat (19) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 64'(bus.out_valid), 64'd0);
    check("abort_busy", 64'(bus.busy), 64'd0);
    sb_q.delete();
    fresh = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (DIV_LAT + 5) @(posedge clk);
    #1;
    check("post_abort_busy", 64'(bus.busy), 64'd0);
    send(OP_ADD, 32'h0000_2000, 32'hFFFF_F000);
    wait_drain();

    // Randomised traffic with random consumer stalls.
    bp_rand = 1'b1;
    for (int i = 0; i < 300; i++) begin
      r  = $urandom_range(0, 15);
      op = (r < 5) ? OP_ADD : (r < 10) ? OP_SUB : (r < 14) ? OP_MUL : OP_DIV;
      if (op == OP_DIV && $urandom_range(0, 3) == 0) begin
        send(op, rand_opnd(), '0);
      end else begin
        send(op, rand_opnd(), rand_opnd());
      end
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    bp_rand = 1'b0;
    bp_fixed = 1'b1;
    @(posedge clk);
    #1;
    wait_drain();
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fxp_alu_seq.md
Name: fxp_alu_seq

Overview:
- Second-generation signed fixed-point ALU: parametrised Qm.n two's-complement datapath.
- Operations: add, subtract, multiply, and a new multi-cycle divide.
- Results saturate and carry status flags.
- Valid/ready handshake on input and output, so the block can sit in a streaming datapath between a producer and a consumer.

Parameters:
- N, 32, total word width in bits, sign included; legal range 8..64.
- Q, 12, fractional bits; 1 <= Q <= N-2.
- DIV_ITERS, N-1+Q (derived localparam), quotient bits produced by the divider, one per cycle.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand/op beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- a  in  N  operand A, signed Qm.Q.
- b  in  N  operand B, signed Qm.Q.
- op  in  2  00 add, 01 sub, 10 mul, 11 div.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  N  signed Qm.Q result.
- ovf  out  1  result was saturated.
- dz  out  1  divide by zero (op 11 with b == 0).
- busy  out  1  divider iterating.

Behaviour:
- Reset (async, rst_n low): out_valid=0, result=0, ovf=0, dz=0, busy=0, FSM=IDLE. in_ready is 0 while rst_n is low.
- Reset mid-divide aborts the divide; the beat is lost and nothing is emitted.
- Accept: a beat transfers when in_valid && in_ready.
- in_ready = (state==IDLE) && (!out_valid || out_ready).
- Output register: result/ovf/dz are held stable while out_valid && !out_ready. The output drops when out_ready is high and no new result loads that cycle.
- Representable range: symmetric, [-(2^(N-1)-1), +(2^(N-1)-1)]. The code 1 followed by N-1 zeros is never output.
  - An exact arithmetic result equal to that code saturates to the negative bound, with ovf=1.
  - Input operands holding that code are treated as -(2^(N-1)).
- Add/sub:
  - Computed in N+1 bits, then clamped to range; ovf=1 if clamped.
  - Latency 1: result valid the cycle after acceptance. Throughput 1/cycle.
- Mul:
  - Magnitudes |a|*|b| form a 2N-bit product; shift right by Q, truncating toward zero.
  - Sign is a[N-1]^b[N-1]; a zero magnitude gives +0.
  - Clamp magnitude to 2^(N-1)-1; ovf=1 if clamped.
  - Latency 1. Throughput 1/cycle.
- Div, b != 0:
  - FSM IDLE -> DIV on acceptance; busy=1.
  - Restoring unsigned division of (|a| << Q) by |b|, DIV_ITERS cycles, one quotient bit per cycle.
  - On the final iteration: apply the sign, clamp (ovf), load the output, out_valid=1, return to IDLE.
  - Latency DIV_ITERS+1 cycles from acceptance to out_valid (default 44).
  - Truncation toward zero.
  - in_ready=0 for the whole DIV state.
- Div, b == 0:
  - No iteration; latency 1; dz=1 and ovf=1.
  - result = +max if a>0, -max if a<0, 0 if a==0 (ovf=0 in that case).
- Flags are registered together with result and are valid only while out_valid.
- Simultaneous events: the output is consumed and a new beat accepted in the same cycle. The add/sub/mul result loads, so out_valid stays 1.
- A div start and an output consume can coincide; out_valid then falls that cycle.

Optional Feature:
- Macro FXP_ALU_ROUND_EN.
- Defined: mul and div round half away from zero before clamping.
  - mul: adds bit Q-1 of the magnitude product.
  - div: one extra iteration gives the guard bit, so div latency = DIV_ITERS+2.
  - Rounding that overflows the magnitude saturates, with ovf=1.
- Undefined: truncation toward zero as specified above; latencies as stated.

Decomposition:
- Package fxp_alu_pkg holds:
  - op encoding constants OP_ADD/OP_SUB/OP_MUL/OP_DIV;
  - FSM state enum (IDLE, DIV);
  - helper functions for magnitude and for saturate-to-N-bits.
- Sub-module fxp_div_seq: start/done iterative unsigned divider, parametrised by width and iterations. It exposes a quotient magnitude and is instantiated once.
- Sign handling, clamp and the add/sub/mul path stay in fxp_alu_seq.

Test Plan (N=32, Q=12):
- add a=0x00001800 (1.5), b=0x00002000 (2.0) -> result 0x00003800 one cycle later, ovf=0. Back-to-back beats give one result per cycle.
- mul a=0x00001800, b=0xFFFFE000 (-2.0) -> 0xFFFFD000 (-3.0), latency 1. Repeat mul 0x7FFFFFFF*0x00002000 -> 0x7FFFFFFF, ovf=1.
- div a=0x00003000 (3.0), b=0x00002000 -> 0x00001800 exactly 44 cycles after accept. busy=1 and in_ready=0 throughout.
- div a=0xFFFFF000 (-1.0), b=0 -> 0x80000001, dz=1, ovf=1, latency 1. Then add 0x7FFFFFFF+0x00000001 -> 0x7FFFFFFF, ovf=1.
- Backpressure: out_ready=0 with a result pending, second beat offered -> in_ready=0 and result held stable. Raising out_ready gives a consume and accept in the same cycle, with no beat lost or duplicated.
- Assert rst_n low at iteration 20 of a div -> out_valid=0, busy=0 immediately. After release, a new add completes normally and no stale div result appears.
